icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Blocking, direct-mapped instruction cache between the IFU AXI-lite read port (upstream, slave side) and the instruction memory AXI-lite read port (downstream, master side).
- Accepts one fetch at a time. Hits return in 2 cycles. A miss refills a whole line using LINE_WORDS single-beat AXI-lite reads, then returns the requested word.
- Supports fence.i-style whole-cache invalidation.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, minimum 2.
- SETS, 16, number of lines; power of two.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_arvalid  in  1  fetch request valid
- ifu_arready  out  1  fetch request accept
- ifu_araddr  in  ADDR_W  fetch address; bits [1:0] ignored
- ifu_rvalid  out  1  fetch data valid
- ifu_rready  in  1  fetch data accept
- ifu_rresp  out  2  response, 00 = OKAY
- ifu_rdata  out  32  instruction word
- mem_arvalid  out  1  refill request valid
- mem_arready  in  1  refill request accept
- mem_araddr  out  ADDR_W  refill word address, 4-byte aligned
- mem_rvalid  in  1  refill data valid
- mem_rready  out  1  refill data accept
- mem_rresp  in  2  refill response
- mem_rdata  in  32  refill word
- cache_inv  in  1  one-cycle pulse: invalidate all lines

Behaviour:
- Address split:
  - word offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Storage: per-set valid bit (async reset to 0), tag array, data array (no reset).
- Reset values: ifu_arready=0, ifu_rvalid=0, ifu_rresp=0, ifu_rdata=0, mem_arvalid=0, mem_rready=0, mem_araddr=0. State = IDLE.
- FSM states: IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP.
- IDLE:
  - ifu_arready=1 unless an invalidate is pending or cache_inv=1 this cycle.
  - On ifu_arvalid&ifu_arready, latch the address and go to LOOKUP.
- LOOKUP:
  - Hit (valid & tag match): register the word into ifu_rdata, set rresp=00, go to RESP. ifu_rvalid rises the cycle after LOOKUP, i.e. 2 cycles after the AR handshake.
  - Miss: clear the refill counter and error flag, go to REFILL_AR.
- REFILL_AR:
  - mem_arvalid=1, mem_araddr = line base + 4*cnt.
  - Hold mem_araddr stable until mem_arready. On handshake go to REFILL_R.
- REFILL_R:
  - mem_rready=1. On mem_rvalid, write mem_rdata to data[index][cnt].
  - If cnt == requested offset, capture the word into ifu_rdata.
  - OR (mem_rresp != 00) into the error flag.
  - If cnt == LINE_WORDS-1, go to RESP. Otherwise cnt++ and go back to REFILL_AR.
  - Refills always start at word 0 and proceed in order (no critical-word-first).
- Refill completion:
  - Error flag clear: set valid[index] and write the tag.
  - Error flag set: valid[index] stays 0 and ifu_rresp = the first non-zero mem_rresp seen.
- RESP: ifu_rvalid=1 until ifu_rready, then go to IDLE. No new AR is accepted in the same cycle.
- Single outstanding request: at most one IFU request and one memory request in flight. The memory-side wait has no timeout.
- cache_inv:
  - Sampled in any state and latched as pending.
  - Applied (all valid bits cleared, one cycle) on the first cycle in IDLE.
  - A refill in progress when the pulse arrives completes and returns its data, but its line is left invalid.
  - cache_inv in the same cycle as an IFU AR in IDLE: invalidate wins, arready=0 that cycle.
- Reset mid-refill:
  - All valid bits clear and the FSM returns to IDLE.
  - Outstanding memory beats after reset are the memory side's responsibility; this block does not drop them.
- Index and tag are taken only from the latched address; upstream address changes after the AR handshake are ignored.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hit_cnt and perf_miss_cnt (64 each) and input perf_clr (1).
  - Counters increment at LOOKUP on hit / miss.
  - Cleared by rst or by perf_clr; if perf_clr and an increment occur in the same cycle, clear wins.
  - Counters wrap at 2^64.
- Undefined: no such ports and no counter logic.

Test Plan:
- Cold miss: AR 0x8000_0008 with memory returning words 0x11,0x22,0x33,0x44 for 0x8000_0000..0x0C → four mem ARs at 0x...00/04/08/0C, then ifu_rdata=0x33, rresp=00.
- Hit: AR 0x8000_000C after the cold miss → ifu_rvalid 2 cycles after handshake, rdata=0x44, no mem_arvalid.
- Conflict: AR 0x8000_0100 (same index 0, different tag) → refill occurs; a following AR 0x8000_0000 misses again.
- Refill error: second beat has mem_rresp=10 → ifu_rresp=10; a repeated AR to the same line refills again.
- Invalidate: cache_inv pulse during REFILL_R → data is still returned; the next AR to the same line misses. A cache_inv concurrent with AR in IDLE → arready=0 that cycle.
- Backpressure: hold ifu_rready=0 for 5 cycles in RESP → rvalid/rdata stay stable and arready stays 0. Assert rst mid-refill → all outputs return to 0 and the next fetch misses.

Source files
------------

// File: rtl/icache_direct.sv
// Blocking direct-mapped instruction cache: AXI-lite read slave toward the IFU, AXI-lite read master toward memory.
// Optional hit/miss performance counters are compiled in with `define ICACHE_PERF_CNT_EN.
module icache_direct #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [1:0]        ifu_rresp,
    output logic [31:0]       ifu_rdata,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [1:0]        mem_rresp,
    input  logic [31:0]       mem_rdata,
    input  logic              cache_inv
`ifdef ICACHE_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [63:0]       perf_hit_cnt,
    output logic [63:0]       perf_miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   word_addr_q, word_addr_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                inv_pend_q, inv_pend_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_araddr_q, mem_araddr_d;
    logic                data_we, tag_we;

    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [31:0]         data_mem [SETS][LINE_WORDS];

    logic [OFF_W-1:0]    off;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                hit, beat_err;
    logic                unused_addr_lsb;

    assign off = word_addr_q[OFF_W-1:0];
    assign idx = word_addr_q[OFF_W +: IDX_W];
    assign tag = word_addr_q[ADDR_W-3 -: TAG_W];
    assign hit = valid_q[idx] && (tag_mem[idx] == tag);
    assign beat_err = (mem_rresp != 2'b00);
    assign unused_addr_lsb = ^ifu_araddr[1:0];

    assign ifu_arready = (state_q == IDLE) && !inv_pend_q && !cache_inv;
    assign ifu_rvalid  = (state_q == RESP);
    assign mem_arvalid = (state_q == REFILL_AR);
    assign mem_rready  = (state_q == REFILL_R);
    assign mem_araddr  = mem_araddr_q;
    assign ifu_rresp   = rresp_q;
    assign ifu_rdata   = rdata_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d      = state_q;
        word_addr_d  = word_addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        valid_d      = valid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        mem_araddr_d = mem_araddr_q;
        inv_pend_d   = inv_pend_q | cache_inv;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (inv_pend_q) begin
                    valid_d    = '0;
                    inv_pend_d = cache_inv;
                end else if (ifu_arvalid && ifu_arready) begin
                    word_addr_d = ifu_araddr[ADDR_W-1:2];
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rdata_d = data_mem[idx][off];
                    rresp_d = 2'b00;
                    state_d = RESP;
                end else begin
                    // The line is about to be overwritten, so it must not hit until refill succeeds.
                    valid_d[idx] = 1'b0;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    rresp_d      = 2'b00;
                    mem_araddr_d = {word_addr_q[ADDR_W-3:OFF_W], {OFF_W{1'b0}}, 2'b00};
                    state_d      = REFILL_AR;
                end
            end
            REFILL_AR: begin
                if (mem_arready) state_d = REFILL_R;
            end
            REFILL_R: begin
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    err_d   = err_q | beat_err;
                    if (cnt_q == off) rdata_d = mem_rdata;
                    if (beat_err && !err_q) rresp_d = mem_rresp;
                    if (cnt_q == LAST_WORD) begin
                        state_d = RESP;
                        if (!err_q && !beat_err && !inv_pend_q && !cache_inv) begin
                            valid_d[idx] = 1'b1;
                            tag_we       = 1'b1;
                        end
                    end else begin
                        cnt_d        = cnt_q + 1'b1;
                        mem_araddr_d = {word_addr_q[ADDR_W-3:OFF_W], cnt_d, 2'b00};
                        state_d      = REFILL_AR;
                    end
                end
            end
            RESP: begin
                if (ifu_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves an invalidate pending, which holds arready low while rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            word_addr_q  <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            inv_pend_q   <= 1'b1;
            valid_q      <= '0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            mem_araddr_q <= '0;
        end else begin
            state_q      <= state_d;
            word_addr_q  <= word_addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            inv_pend_q   <= inv_pend_d;
            valid_q      <= valid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            mem_araddr_q <= mem_araddr_d;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[idx][cnt_q] <= mem_rdata;
        if (tag_we)  tag_mem[idx] <= tag;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [63:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == LOOKUP) && hit;
    assign miss_evt = (state_q == LOOKUP) && !hit;

    always_comb begin
        perf_hit_d  = perf_clr ? '0 : perf_hit_q + 64'(hit_evt);
        perf_miss_d = perf_clr ? '0 : perf_miss_q + 64'(miss_evt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit_cnt  = perf_hit_q;
    assign perf_miss_cnt = perf_miss_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: stimulus pushes expected IFU responses and memory ARs,
// independent monitor and memory model processes pop and compare.
module tb_icache_direct;

    logic        clk, rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [63:0] ifu_araddr;
    logic [1:0]  ifu_rresp;
    logic [31:0] ifu_rdata;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [63:0] mem_araddr;
    logic [1:0]  mem_rresp;
    logic [31:0] mem_rdata;
    logic        cache_inv;
`ifdef ICACHE_PERF_CNT_EN
    logic        perf_clr;
    logic [63:0] perf_hit_cnt, perf_miss_cnt;
`endif

    icache_direct dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rresp(mem_rresp), .mem_rdata(mem_rdata),
        .cache_inv(cache_inv)
`ifdef ICACHE_PERF_CNT_EN
        , .perf_clr(perf_clr), .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          lat_chk;
        int          hs_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_ar[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [63:0] err_addr = '0;
    int          err_left = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 32'h0000_0011;
            64'h8000_0004: return 32'h0000_0022;
            64'h8000_0008: return 32'h0000_0033;
            64'h8000_000C: return 32'h0000_0044;
            64'h8000_0100: return 32'hAAAA_0000;
            64'h8000_0104: return 32'hAAAA_0001;
            64'h8000_0108: return 32'hAAAA_0002;
            64'h8000_010C: return 32'hAAAA_0003;
            64'h8000_0200: return 32'hBBBB_0000;
            64'h8000_0204: return 32'hBBBB_0001;
            64'h8000_0208: return 32'hBBBB_0002;
            64'h8000_020C: return 32'hBBBB_0003;
            default:       return 32'hDEAD_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    // Memory model: stalls arready one cycle per AR, answers each R beat immediately.
    initial begin
        logic        stall;
        logic [63:0] stall_addr, cur_addr, e;
        stall = 1'b0; stall_addr = '0; cur_addr = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rresp = 2'b00; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_arready = 1'b0;
                mem_rvalid  = 1'b0;
                stall       = 1'b0;
            end else begin
                mem_arready = 1'b0;
                if (mem_arvalid) begin
                    if (!stall) begin
                        stall      = 1'b1;
                        stall_addr = mem_araddr;
                    end else begin
                        check("mem_araddr_stable", mem_araddr, stall_addr);
                        stall       = 1'b0;
                        mem_arready = 1'b1;
                        cur_addr    = mem_araddr;
                        if (exp_ar.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL mem_ar_unexpected: got %h expected none", mem_araddr);
                        end else begin
                            e = exp_ar.pop_front();
                            check("mem_araddr", mem_araddr, e);
                        end
                    end
                end
                mem_rvalid = 1'b0;
                mem_rresp  = 2'b00;
                if (mem_rready) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(cur_addr);
                    if (cur_addr == err_addr && err_left > 0) begin
                        mem_rresp = 2'b10;
                        err_left--;
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every IFU R handshake.
    initial begin
        bit   seen;
        int   rv_cyc;
        exp_t e;
        seen = 1'b0; rv_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (ifu_rvalid) begin
                if (!seen) begin
                    seen   = 1'b1;
                    rv_cyc = cyc;
                end
                if (ifu_rready) begin
                    seen = 1'b0;
                    if (sb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL ifu_r_unexpected: got %h expected none", ifu_rdata);
                    end else begin
                        e = sb.pop_front();
                        check("ifu_rdata", 64'(ifu_rdata), 64'(e.data));
                        check("ifu_rresp", 64'(ifu_rresp), 64'(e.resp));
                        if (e.lat_chk) check("hit_latency", 64'(rv_cyc - e.hs_cyc), 64'd2);
                    end
                end
            end
        end
    end

    task automatic push_line(input logic [63:0] base);
        for (int i = 0; i < 4; i++) exp_ar.push_back(base + 64'(4 * i));
    endtask

    task automatic issue(input logic [63:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input bit lat_chk, input bit push);
        exp_t e;
        int   hs;
        bit   ok;
        ok = 1'b0; hs = 0;
        @(posedge clk); #1;
        ifu_araddr  = addr;
        ifu_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifu_arready) begin
                hs = cyc;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        ifu_araddr  = 64'h1234_5678_9ABC_DEF0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL ifu_ar_timeout: got no arready expected handshake for %h", addr);
        end else if (push) begin
            e.data = data; e.resp = resp; e.lat_chk = lat_chk; e.hs_cyc = hs;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ifu_rvalid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic wait_mem_rready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_rready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL mem_rready_timeout: got 0 expected 1");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"},    64'(ifu_arready), 64'd0);
        check({tag, "_rvalid"},     64'(ifu_rvalid),  64'd0);
        check({tag, "_rresp"},      64'(ifu_rresp),   64'd0);
        check({tag, "_rdata"},      64'(ifu_rdata),   64'd0);
        check({tag, "_mem_arvalid"}, 64'(mem_arvalid), 64'd0);
        check({tag, "_mem_rready"},  64'(mem_rready),  64'd0);
        check({tag, "_mem_araddr"},  mem_araddr,       64'd0);
    endtask

    initial begin
        bit rv_ok;
        rst = 1'b1; ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b1; cache_inv = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Cold miss: whole line fetched in order, requested word 2 returned.
        push_line(64'h8000_0000);
        issue(64'h8000_0008, 32'h0000_0033, 2'b00, 1'b0, 1'b1);
        drain();

        // Hit: no memory traffic, rvalid 2 cycles after handshake.
        issue(64'h8000_000C, 32'h0000_0044, 2'b00, 1'b1, 1'b1);
        drain();

        // Conflict on index 0 evicts the first line.
        push_line(64'h8000_0100);
        issue(64'h8000_0104, 32'hAAAA_0001, 2'b00, 1'b0, 1'b1);
        drain();
        push_line(64'h8000_0000);
        issue(64'h8000_0000, 32'h0000_0011, 2'b00, 1'b0, 1'b1);
        drain();

        // Refill error on beat 1: SLVERR reported, line stays invalid and refills again.
        err_addr = 64'h8000_0204;
        err_left = 1;
        push_line(64'h8000_0200);
        issue(64'h8000_0208, 32'hBBBB_0002, 2'b10, 1'b0, 1'b1);
        drain();
        push_line(64'h8000_0200);
        issue(64'h8000_0208, 32'hBBBB_0002, 2'b00, 1'b0, 1'b1);
        drain();
        issue(64'h8000_020C, 32'hBBBB_0003, 2'b00, 1'b1, 1'b1);
        drain();

        // Invalidate during refill: data still returned, line left invalid, all lines cleared.
        push_line(64'h8000_0010);
        issue(64'h8000_0010, 32'hDEAD_0010, 2'b00, 1'b0, 1'b1);
        wait_mem_rready();
        @(posedge clk); #1 cache_inv = 1'b1;
        @(posedge clk); #1 cache_inv = 1'b0;
        drain();
        push_line(64'h8000_0010);
        issue(64'h8000_0014, 32'hDEAD_0014, 2'b00, 1'b0, 1'b1);
        drain();
        push_line(64'h8000_0200);
        issue(64'h8000_020C, 32'hBBBB_0003, 2'b00, 1'b0, 1'b1);
        drain();

        // cache_inv together with AR in IDLE: invalidate wins, then the fetch misses.
        @(posedge clk); #1;
        ifu_araddr = 64'h8000_0014; ifu_arvalid = 1'b1; cache_inv = 1'b1;
        @(negedge clk);
        check("arready_inv_same_cycle", 64'(ifu_arready), 64'd0);
        @(posedge clk); #1 cache_inv = 1'b0;
        @(negedge clk);
        check("arready_inv_pending", 64'(ifu_arready), 64'd0);
        push_line(64'h8000_0010);
        issue(64'h8000_0014, 32'hDEAD_0014, 2'b00, 1'b0, 1'b1);
        drain();

        // Backpressure: response held stable, no new AR accepted.
        @(posedge clk); #1 ifu_rready = 1'b0;
        issue(64'h8000_0014, 32'hDEAD_0014, 2'b00, 1'b1, 1'b1);
        rv_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ifu_rvalid) begin
                rv_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("bp_rvalid_seen", 64'(rv_ok), 64'd1);
        ifu_araddr = 64'h8000_0000; ifu_arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rvalid", 64'(ifu_rvalid), 64'd1);
            check("bp_rdata", 64'(ifu_rdata), 64'hDEAD_0014);
            check("bp_arready", 64'(ifu_arready), 64'd0);
        end
        @(posedge clk); #1;
        ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        drain();

        // Reset mid-refill: outputs return to 0, the previously valid line misses.
        exp_ar.push_back(64'h8000_0030);
        issue(64'h8000_0030, 32'h0, 2'b00, 1'b0, 1'b0);
        wait_mem_rready();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        push_line(64'h8000_0010);
        issue(64'h8000_0014, 32'hDEAD_0014, 2'b00, 1'b0, 1'b1);
        drain();

        repeat (5) @(negedge clk);
        check("mem_ar_all_seen", 64'(exp_ar.size()), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
